// File: rtl/pulse_duty_meter_pkg.sv
// Shared types and defaults for the pulse duty meter: FSM encoding, default
// sizing and a small helper that turns a duty code into an expected high time.
package pulse_duty_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_STUCK = 3'd4
    } state_t;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_SYNC_STAGES = 2;

    // Duty codes are expressed in eighths of the divider period.
    localparam int DUTY_CODE_STEPS = 8;

    function automatic int duty_code_to_high(input int code, input int period);
        return (code * period + DUTY_CODE_STEPS / 2) / DUTY_CODE_STEPS;
    endfunction

endpackage

// File: rtl/pulse_duty_meter_if.sv
// Measurement bus of the pulse duty meter: waveform and enable in, results,
// stuck flags and the FSM state out.
interface pulse_duty_meter_if #(
    parameter int CNT_W = pulse_duty_meter_pkg::DEF_CNT_W
) ();

    logic                          en;
    logic                          sig_in;
    logic [CNT_W-1:0]              high_cnt;
    logic [CNT_W-1:0]              period_cnt;
    logic                          meas_valid;
    logic                          stuck;
    logic                          stuck_level;
    pulse_duty_meter_pkg::state_t  dbg_state;

    // meas_valid is a single-cycle strobe with no back-pressure: the consumer
    // must take high_cnt/period_cnt in the cycle meas_valid is 1; both values
    // then hold until the next strobe or reset.
    modport master (
        output en,
        output sig_in,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck,
        input  stuck_level,
        input  dbg_state
    );

    modport slave (
        input  en,
        input  sig_in,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck,
        output stuck_level,
        output dbg_state
    );

endinterface

// File: rtl/pulse_duty_meter_sync_edge_det.sv
// Brings the monitored waveform into the clk domain and flags its edges
// relative to the previous synchronized sample.
module pulse_duty_meter_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/pulse_duty_meter.sv
// Measures high time and period of a synchronized waveform in clk cycles,
// publishing one result per full period and flagging a stuck waveform.
module pulse_duty_meter
    import pulse_duty_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    pulse_duty_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             s;
    logic             rise;
    logic             fall;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] h_lat_q;
    logic [CNT_W-1:0] h_lat_d;
    logic             publish;
    logic             timeout;

    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] period_q;
    logic             meas_valid_q;
    logic             stuck_level_q;

    pulse_duty_meter_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    // Saturating increment keeps long waveforms from wrapping into a small count.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout = (cnt_q == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        h_lat_d = h_lat_q;
        publish = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else if (timeout) begin
                        state_d = ST_STUCK;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d = ST_LOW;
                        h_lat_d = cnt_q;
                    end else if (timeout) begin
                        state_d = ST_STUCK;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                        publish = 1'b1;
                    end else if (timeout) begin
                        state_d = ST_STUCK;
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            h_lat_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_lat_q <= h_lat_d;
        end
    end

    // Results are registered so meas_valid lands one cycle after the closing rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_q        <= '0;
            period_q      <= '0;
            meas_valid_q  <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            meas_valid_q <= publish;
            if (publish) begin
                high_q   <= h_lat_q;
                period_q <= cnt_q;
            end
            if (state_d == ST_STUCK) begin
                stuck_level_q <= s;
            end
        end
    end

    assign bus.high_cnt    = high_q;
    assign bus.period_cnt  = period_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.stuck       = (state_q == ST_STUCK);
    assign bus.stuck_level = stuck_level_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_duty_meter.sv
// Directed bench for pulse_duty_meter: waveform scenarios with hand-computed
// high/period results, stuck detection, enable drop and asynchronous reset.
module tb_pulse_duty_meter;
    import pulse_duty_meter_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [CNT_W-1:0] cap_h[$];
    logic [CNT_W-1:0] cap_p[$];
    int               cap_c[$];
    int               stuck_on_cyc = -1;
    logic             prev_stuck = 1'b0;

    pulse_duty_meter_if #(.CNT_W(CNT_W)) bus ();

    pulse_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result capture on the falling edge
    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1) begin
            cap_h.push_back(bus.high_cnt);
            cap_p.push_back(bus.period_cnt);
            cap_c.push_back(cyc);
        end
        if (bus.stuck === 1'b1 && prev_stuck === 1'b0) stuck_on_cyc = cyc;
        prev_stuck = bus.stuck;
    end

    // Drivers
    task automatic step(input logic v);
        bus.sig_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic restart();
        bus.en = 1'b0;
        repeat (2) step(1'b0);
        bus.en = 1'b1;
        cap_h.delete();
        cap_p.delete();
        cap_c.delete();
        stuck_on_cyc = -1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        bus.sig_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.high_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_high_cnt: got %0d expected 0", bus.high_cnt); end
        n_tests++;
        if (bus.period_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_period_cnt: got %0d expected 0", bus.period_cnt); end
        n_tests++;
        if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_meas_valid: got %b expected 0", bus.meas_valid); end
        n_tests++;
        if (bus.stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", bus.stuck); end
        n_tests++;
        if (bus.stuck_level !== 1'b0) begin n_fail++; $display("FAIL reset_stuck_level: got %b expected 0", bus.stuck_level); end
        n_tests++;
        if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE); end
        rst = 1'b0;
        repeat (3) step(1'b0);
        n_tests++;
        if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_without_en: got %0d expected %0d", bus.dbg_state, ST_IDLE); end
    endtask

    task automatic test_duty_2_3();
        restart();
        repeat (4) step(1'b0);
        repeat (6) wave(2, 3);
        repeat (6) step(1'b0);
        n_tests++;
        if (cap_h.size() != 5) begin n_fail++; $display("FAIL d23_count: got %0d expected 5", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 5; i++) begin
            n_tests++;
            if (cap_h[i] !== 8'd2 || cap_p[i] !== 8'd5) begin
                n_fail++;
                $display("FAIL d23_result[%0d]: got %0d/%0d expected 2/5", i, cap_h[i], cap_p[i]);
            end
            if (i > 0) begin
                n_tests++;
                if (cap_c[i] - cap_c[i-1] != 5) begin
                    n_fail++;
                    $display("FAIL d23_spacing[%0d]: got %0d expected 5", i, cap_c[i] - cap_c[i-1]);
                end
            end
        end
    endtask

    task automatic test_duty_change();
        logic [CNT_W-1:0] exp_q[$];
        logic [CNT_W-1:0] exp_p_q[$];
        exp_q   = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd4, 8'd4};
        exp_p_q = '{8'd5, 8'd5, 8'd5, 8'd3, 8'd5, 8'd5};
        restart();
        repeat (4) step(1'b0);
        repeat (3) wave(2, 3);
        wave(2, 1);
        repeat (3) wave(4, 1);
        repeat (6) step(1'b0);
        n_tests++;
        if (cap_h.size() != exp_q.size()) begin n_fail++; $display("FAIL change_count: got %0d expected %0d", cap_h.size(), exp_q.size()); end
        for (int i = 0; i < cap_h.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (cap_h[i] !== exp_q[i] || cap_p[i] !== exp_p_q[i]) begin
                n_fail++;
                $display("FAIL change_result[%0d]: got %0d/%0d expected %0d/%0d", i, cap_h[i], cap_p[i], exp_q[i], exp_p_q[i]);
            end
        end
    endtask

    task automatic test_stuck_high();
        int c0;
        int c1;
        restart();
        repeat (4) step(1'b0);
        c0 = cyc;
        repeat (300) step(1'b1);
        n_tests++;
        if (bus.stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_hi_flag: got %b expected 1", bus.stuck); end
        n_tests++;
        if (bus.stuck_level !== 1'b1) begin n_fail++; $display("FAIL stuck_hi_level: got %b expected 1", bus.stuck_level); end
        n_tests++;
        if (bus.dbg_state !== ST_STUCK) begin n_fail++; $display("FAIL stuck_hi_state: got %0d expected %0d", bus.dbg_state, ST_STUCK); end
        n_tests++;
        if (stuck_on_cyc != c0 + 3 + TIMEOUT) begin n_fail++; $display("FAIL stuck_hi_onset: got %0d expected %0d", stuck_on_cyc, c0 + 3 + TIMEOUT); end
        n_tests++;
        if (cap_h.size() != 0) begin n_fail++; $display("FAIL stuck_hi_no_result: got %0d expected 0", cap_h.size()); end
        repeat (3) step(1'b0);
        n_tests++;
        if (bus.stuck !== 1'b1 || bus.stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_follow_low: got stuck=%b level=%b expected 1/0", bus.stuck, bus.stuck_level);
        end
        c1 = cyc;
        step(1'b1);
        step(1'b1);
        n_tests++;
        if (bus.stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_before_rise: got %b expected 1 (cyc %0d)", bus.stuck, c1); end
        step(1'b0);
        n_tests++;
        if (bus.stuck !== 1'b0 || bus.dbg_state !== ST_HIGH) begin
            n_fail++;
            $display("FAIL stuck_clear_on_rise: got stuck=%b state=%0d expected 0/%0d", bus.stuck, bus.dbg_state, ST_HIGH);
        end
        repeat (2) step(1'b0);
        repeat (2) wave(2, 3);
        repeat (6) step(1'b0);
        n_tests++;
        if (cap_h.size() != 2) begin n_fail++; $display("FAIL stuck_resume_count: got %0d expected 2", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 2; i++) begin
            n_tests++;
            if (cap_h[i] !== 8'd2 || cap_p[i] !== 8'd5) begin
                n_fail++;
                $display("FAIL stuck_resume_result[%0d]: got %0d/%0d expected 2/5", i, cap_h[i], cap_p[i]);
            end
        end
    endtask

    task automatic test_min_period();
        restart();
        repeat (4) step(1'b0);
        repeat (8) wave(1, 1);
        repeat (4) step(1'b0);
        n_tests++;
        if (cap_h.size() != 7) begin n_fail++; $display("FAIL min_count: got %0d expected 7", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 7; i++) begin
            n_tests++;
            if (cap_h[i] !== 8'd1 || cap_p[i] !== 8'd2) begin
                n_fail++;
                $display("FAIL min_result[%0d]: got %0d/%0d expected 1/2", i, cap_h[i], cap_p[i]);
            end
            if (i > 0) begin
                n_tests++;
                if (cap_c[i] - cap_c[i-1] != 2) begin
                    n_fail++;
                    $display("FAIL min_spacing[%0d]: got %0d expected 2", i, cap_c[i] - cap_c[i-1]);
                end
            end
        end
        repeat (300) step(1'b0);
        n_tests++;
        if (bus.stuck !== 1'b1 || bus.stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_low: got stuck=%b level=%b expected 1/0", bus.stuck, bus.stuck_level);
        end
        n_tests++;
        if (cap_h.size() != 7) begin n_fail++; $display("FAIL stuck_low_no_result: got %0d expected 7", cap_h.size()); end
    endtask

    task automatic test_en_drop();
        restart();
        repeat (4) step(1'b0);
        repeat (3) wave(2, 3);
        repeat (2) step(1'b1);
        repeat (4) step(1'b0);
        bus.en = 1'b0;
        repeat (2) step(1'b0);
        n_tests++;
        if (bus.dbg_state !== ST_IDLE || bus.meas_valid !== 1'b0 || bus.stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_idle: got state=%0d mv=%b stuck=%b expected %0d/0/0", bus.dbg_state, bus.meas_valid, bus.stuck, ST_IDLE);
        end
        n_tests++;
        if (bus.high_cnt !== 8'd2 || bus.period_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL en_drop_hold: got %0d/%0d expected 2/5", bus.high_cnt, bus.period_cnt);
        end
        repeat (3) wave(2, 3);
        n_tests++;
        if (cap_h.size() != 3) begin n_fail++; $display("FAIL en_drop_count: got %0d expected 3", cap_h.size()); end
        n_tests++;
        if (bus.high_cnt !== 8'd2 || bus.period_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL en_off_hold: got %0d/%0d expected 2/5", bus.high_cnt, bus.period_cnt);
        end
        bus.en = 1'b1;
        repeat (3) step(1'b0);
        repeat (2) wave(3, 2);
        step(1'b1);
        repeat (6) step(1'b0);
        n_tests++;
        if (cap_h.size() != 5) begin n_fail++; $display("FAIL reenable_count: got %0d expected 5", cap_h.size()); end
        for (int i = 3; i < cap_h.size() && i < 5; i++) begin
            n_tests++;
            if (cap_h[i] !== 8'd3 || cap_p[i] !== 8'd5) begin
                n_fail++;
                $display("FAIL reenable_result[%0d]: got %0d/%0d expected 3/5", i, cap_h[i], cap_p[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (4) step(1'b0);
        repeat (2) wave(2, 3);
        repeat (4) step(1'b1);
        n_tests++;
        if (bus.dbg_state !== ST_HIGH || bus.high_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL pre_reset: got state=%0d high=%0d expected %0d/2", bus.dbg_state, bus.high_cnt, ST_HIGH);
        end
        #2;
        rst = 1'b1;
        bus.sig_in = 1'b0;
        #1;
        n_tests++;
        if (bus.high_cnt !== 8'd0 || bus.period_cnt !== 8'd0 || bus.meas_valid !== 1'b0 ||
            bus.stuck !== 1'b0 || bus.stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %0d/%0d mv=%b st=%b lvl=%b expected all 0",
                     bus.high_cnt, bus.period_cnt, bus.meas_valid, bus.stuck, bus.stuck_level);
        end
        n_tests++;
        if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL async_reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap_h.delete();
        cap_p.delete();
        cap_c.delete();
        repeat (4) step(1'b0);
        repeat (3) wave(2, 3);
        repeat (6) step(1'b0);
        n_tests++;
        if (cap_h.size() != 2) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 2", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 2; i++) begin
            n_tests++;
            if (cap_h[i] !== 8'd2 || cap_p[i] !== 8'd5) begin
                n_fail++;
                $display("FAIL post_reset_result[%0d]: got %0d/%0d expected 2/5", i, cap_h[i], cap_p[i]);
            end
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.sig_in = 1'b0;
        test_reset();
        test_duty_2_3();
        test_duty_change();
        test_stuck_high();
        test_min_period();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
